reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with a per-register busy
//  scoreboard. Sits in the decode stage: supplies operands to decode and hazard
//  logic, takes the single writeback port from the WB stage, and tracks which
//  architectural registers have an in-flight producer so decode can stall.
// PARAMETERS
//  XLEN    32   data width of each register, in bits
//  NREGS   32   number of architectural registers (power of two, >= 2)
//  AW      5    address width; must equal $clog2(NREGS)
//  NRD     2    number of read ports (1..4)
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         synchronous reset, active-high
//  rd_addr    in   NRD*AW    read addresses; port i is bits [i*AW +: AW]
//  rd_data    out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN]
//  rd_busy    out  NRD       1 = register on port i has a pending producer
//  wr_en      in   1         writeback enable
//  wr_addr    in   AW        writeback register index
//  wr_data    in   XLEN      writeback value
//  iss_en     in   1         an instruction writing iss_addr was issued
//  iss_addr   in   AW        destination register of the issued instruction
//  flush      in   1         pipeline flush; discards all pending producers
// BEHAVIOUR
//  - Storage: NREGS x XLEN array plus an NREGS-bit busy vector.
//  - Reset: rst high at posedge clears every register to 0 and every busy bit
//    to 0. While rst is high, rd_data = 0 and rd_busy = 0 on all ports
//    (combinational gating). Reset mid-operation discards pending writes and
//    busy state.
//  - Register 0: reads 0, never busy; writes and issues to index 0 ignored.
//  - Reads: combinational, zero latency; each port fully independent; any
//    number of ports may read the same index.
//  - Write: wr_en && wr_addr != 0 -> reg[wr_addr] <= wr_data at posedge.
//    Visible on rd_data the cycle after (see REGFILE_BYPASS_EN).
//  - Busy update at posedge, priority high to low:
//      1. rst               -> busy <= 0
//      2. flush             -> busy <= 0 (iss_en that cycle ignored; wr_en
//                              still updates data)
//      3. iss_en, addr != 0 -> busy[iss_addr] <= 1
//      4. wr_en,  addr != 0 -> busy[wr_addr]  <= 0, unless same index as a
//                              simultaneous issue (new producer wins, stays 1)
//    Issue and writeback to different indices in one cycle both take effect.
//  - Issuing to an already-busy register is legal; bit stays 1 (WAW; last
//    writeback clears it, in-order WB is the pipeline's responsibility).
//  - Writeback to a non-busy register is legal; data written, busy stays 0.
//  - Address wrap: indices are AW bits; no out-of-range access possible.
//  - rd_busy[i] = busy[rd_addr_i] (subject to bypass below).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through. A read port whose address matches
//    wr_addr (non-zero) while wr_en is high returns wr_data and rd_busy=0 in
//    the same cycle (unless iss_en to that index in the same cycle, then
//    rd_busy=1). Adds one comparator + mux per port.
//  REGFILE_BYPASS_EN undefined: no forwarding; same-cycle read returns the old
//    value and old busy bit; new value visible next cycle.
// TESTING
//  1. Fill regs 1..31 with 0x100+i, then rst 1 cycle -> all ports read 0,
//     rd_busy all 0, while rst high and after release.
//  2. wr_en, wr_addr=0, wr_data=0xDEADBEEF; then read x0 on all ports -> 0;
//     iss_en to x0 -> rd_busy stays 0.
//  3. Write x5=0x1234 and read x5 same cycle -> 0x1234 with BYPASS_EN, old
//     value without; next cycle 0x1234 in both builds.
//  4. iss x7 at t0 -> rd_busy=1 from t1; wr x7=0x55 + iss x7 at t3 -> busy
//     stays 1; wr x7 at t5 -> busy 0 at t6, data 0x55 then new value.
//  5. Busy x3,x9; flush with iss x4 same cycle -> x3,x4,x9 all not busy
//     next cycle.
//  6. NRD=4, distinct addrs 1,2,31,0 -> each port returns its own value,
//     port 3 returns 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_ok;
    logic             iss_ok;

    assign wr_ok  = wr_en && (wr_addr != '0);
    assign iss_ok = iss_en && (iss_addr != '0) && !flush;

    // Issue is applied after writeback so a new producer to the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_ok) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_ok) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (addr == wr_addr)) begin
                data = wr_data;
                busy = iss_ok && (iss_addr == addr);
            end
`endif
            if (rst || (addr == '0)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb with four read ports.
// Expectations for same-cycle reads follow the REGFILE_BYPASS_EN build setting.
module tb_reg_file_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    int errors = 0;
    int checks = 0;

    reg_file_sb #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .AW   (AW),
        .NRD  (NRD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .flush   (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] data_of(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Fill x1..x31, make x9 busy, then reset
        for (int i = 1; i < 32; i++) begin
            wr(AW'(i), 32'h100 + i);
            tick();
        end
        wr_en    = 1'b0;
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        tick();
        iss_en = 1'b0;
        set_rd(0, 5'd5);
        set_rd(1, 5'd9);
        set_rd(2, 5'd31);
        set_rd(3, 5'd17);
        #1;
        chk("fill_x5", data_of(0), 32'h105);
        chk("fill_x31", data_of(2), 32'h11f);
        chk("pre_rst_busy", 32'(rd_busy), 32'h2);
        rst = 1'b1;
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("rst_hi_data%0d", p), data_of(p), 32'h0);
        chk("rst_hi_busy", 32'(rd_busy), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("rst_lo_data%0d", p), data_of(p), 32'h0);
        chk("rst_lo_busy", 32'(rd_busy), 32'h0);

        // x0 ignores writes and issues
        wr(5'd0, 32'hDEADBEEF);
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        rd_addr  = '0;
        tick();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("x0_data%0d", p), data_of(p), 32'h0);
        chk("x0_busy", 32'(rd_busy), 32'h0);

        // Same-cycle read of a write
        wr(5'd5, 32'h1234);
        set_rd(0, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_x5_same", data_of(0), 32'h1234);
`else
        chk("byp_x5_same", data_of(0), 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        chk("x5_next", data_of(0), 32'h1234);

        // Busy lifecycle of x7 with WAW re-issue
        set_rd(0, 5'd7);
        iss_en   = 1'b1;
        iss_addr = 5'd7;
        #1;
        chk("t0_busy", 32'(rd_busy[0]), 32'h0);
        tick();
        iss_en = 1'b0;
        #1;
        chk("t1_busy", 32'(rd_busy[0]), 32'h1);
        tick();
        chk("t2_busy", 32'(rd_busy[0]), 32'h1);
        tick();
        wr(5'd7, 32'h55);
        iss_en = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t3_data", data_of(0), 32'h55);
`else
        chk("t3_data", data_of(0), 32'h0);
`endif
        chk("t3_busy", 32'(rd_busy[0]), 32'h1);
        tick();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        #1;
        chk("t4_busy", 32'(rd_busy[0]), 32'h1);
        chk("t4_data", data_of(0), 32'h55);
        tick();
        wr(5'd7, 32'h66);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t5_data", data_of(0), 32'h66);
        chk("t5_busy", 32'(rd_busy[0]), 32'h0);
`else
        chk("t5_data", data_of(0), 32'h55);
        chk("t5_busy", 32'(rd_busy[0]), 32'h1);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        chk("t6_busy", 32'(rd_busy[0]), 32'h0);
        chk("t6_data", data_of(0), 32'h66);

        // Flush discards producers, ignores same-cycle issue, keeps the write
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        tick();
        iss_addr = 5'd9;
        tick();
        iss_en = 1'b0;
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        set_rd(2, 5'd9);
        set_rd(3, 5'd0);
        #1;
        chk("pre_flush_busy", 32'(rd_busy), 32'h5);
        flush    = 1'b1;
        iss_en   = 1'b1;
        iss_addr = 5'd4;
        wr(5'd3, 32'h33);
        tick();
        flush  = 1'b0;
        iss_en = 1'b0;
        wr_en  = 1'b0;
        #1;
        chk("post_flush_busy", 32'(rd_busy), 32'h0);
        chk("flush_wr_x3", data_of(0), 32'h33);

        // Issue and writeback to different indices in one cycle
        set_rd(0, 5'd12);
        set_rd(1, 5'd13);
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        tick();
        iss_addr = 5'd13;
        wr(5'd12, 32'hAB);
        tick();
        iss_en = 1'b0;
        wr_en  = 1'b0;
        #1;
        chk("split_busy", 32'(rd_busy[1:0]), 32'h2);
        chk("split_x12", data_of(0), 32'hAB);

        // Writeback to a non-busy register leaves it idle
        wr(5'd20, 32'h2020);
        set_rd(0, 5'd20);
        tick();
        wr_en = 1'b0;
        #1;
        chk("nb_wr_data", data_of(0), 32'h2020);
        chk("nb_wr_busy", 32'(rd_busy[0]), 32'h0);

        // Four independent ports
        wr(5'd1, 32'h11111111);
        tick();
        wr(5'd2, 32'h22222222);
        tick();
        wr(5'd31, 32'hFFFF0001);
        tick();
        wr_en = 1'b0;
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        set_rd(2, 5'd31);
        set_rd(3, 5'd0);
        #1;
        chk("p0_x1", data_of(0), 32'h11111111);
        chk("p1_x2", data_of(1), 32'h22222222);
        chk("p2_x31", data_of(2), 32'hFFFF0001);
        chk("p3_x0", data_of(3), 32'h0);
        set_rd(3, 5'd2);
        #1;
        chk("p3_x2_shared", data_of(3), 32'h22222222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
